// File: rtl/periph_bus_sequencer_if.sv
// periph_bus_sequencer_if: command/response handshake plus shared peripheral register bus.
// rsp_err exists only when SEQ_INVALID_DETECT_EN is defined.
interface periph_bus_sequencer_if #(
  parameter int NUM_PERIPH = 128
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [6:0]            cmd_periph;
  logic [7:0]            cmd_reg;
  logic                  cmd_rw;
  logic [31:0]           cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;
  logic [2:0]            rsp_size;
`ifdef SEQ_INVALID_DETECT_EN
  logic                  rsp_err;
`endif
  logic [7:0]            reg_addr;
  logic                  rw;
  logic [31:0]           bus_wdata;
  logic                  bus_wdata_oe;
  logic [31:0]           bus_rdata;
  logic [2:0]            reg_size;
  logic [NUM_PERIPH-1:0] select;
  modport master (
    input  cmd_valid, cmd_periph, cmd_reg, cmd_rw, cmd_wdata, rsp_ready, bus_rdata, reg_size,
    output cmd_ready, rsp_valid, rsp_data, rsp_size, reg_addr, rw, bus_wdata, bus_wdata_oe, select
`ifdef SEQ_INVALID_DETECT_EN
    , output rsp_err
`endif
  );
  modport slave (
    output cmd_valid, cmd_periph, cmd_reg, cmd_rw, cmd_wdata, rsp_ready, bus_rdata, reg_size,
    input  cmd_ready, rsp_valid, rsp_data, rsp_size, reg_addr, rw, bus_wdata, bus_wdata_oe, select
`ifdef SEQ_INVALID_DETECT_EN
    , input rsp_err
`endif
  );
endinterface

// File: rtl/periph_bus_sequencer.sv
// periph_bus_sequencer: sole master of the peripheral register bus; runs setup/strobe/hold per command.
// Optional SEQ_INVALID_DETECT_EN adds rsp_err for out-of-range periph or zero-size reads.
module periph_bus_sequencer #(
  parameter int NUM_PERIPH    = 128,
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input logic                   clk,
  input logic                   rst,
  periph_bus_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [6:0]            periph_q, periph_d;
  logic [7:0]            addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d, data_q, data_d;
  logic [2:0]            size_q, size_d;
  logic                  rw_q, rw_d, oe_q, oe_d;
  logic [NUM_PERIPH-1:0] sel_q, sel_d;
  logic                  in_range, done;
  assign in_range = 32'(periph_q) < NUM_PERIPH;
  assign done     = cnt_q == 4'd0;
  always_comb begin
    state_d  = state_q;
    cnt_d    = done ? cnt_q : cnt_q - 4'd1;
    periph_d = periph_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rw_d     = rw_q;
    oe_d     = oe_q;
    sel_d    = sel_q;
    data_d   = data_q;
    size_d   = size_q;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        state_d  = SETUP;
        cnt_d    = 4'(SETUP_CYCLES - 1);
        periph_d = bus.cmd_periph;
        addr_d   = bus.cmd_reg;
        wdata_d  = bus.cmd_wdata;
        rw_d     = bus.cmd_rw;
        oe_d     = ~bus.cmd_rw;
      end
      SETUP: if (done) begin
        state_d = STROBE;
        cnt_d   = 4'(STROBE_CYCLES - 1);
        sel_d   = in_range ? NUM_PERIPH'(1) << periph_q : '0;
      end
      // read data is taken on the edge that ends the last strobe cycle
      STROBE: if (done) begin
        state_d = HOLD;
        cnt_d   = 4'(HOLD_CYCLES - 1);
        sel_d   = '0;
        data_d  = (rw_q && in_range) ? bus.bus_rdata : '0;
        size_d  = (rw_q && in_range) ? bus.reg_size : '0;
      end
      HOLD: if (done) begin
        state_d = RESP;
        rw_d    = 1'b1;
        oe_d    = 1'b0;
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      periph_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rw_q     <= 1'b1;
      oe_q     <= 1'b0;
      sel_q    <= '0;
      data_q   <= '0;
      size_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      periph_q <= periph_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rw_q     <= rw_d;
      oe_q     <= oe_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      size_q   <= size_d;
    end
  assign bus.cmd_ready    = state_q == IDLE && !rst;
  assign bus.rsp_valid    = state_q == RESP;
  assign bus.rsp_data     = data_q;
  assign bus.rsp_size     = size_q;
  assign bus.reg_addr     = addr_q;
  assign bus.rw           = rw_q;
  assign bus.bus_wdata    = wdata_q;
  assign bus.bus_wdata_oe = oe_q;
  assign bus.select       = sel_q;
`ifdef SEQ_INVALID_DETECT_EN
  logic err_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) err_q <= 1'b0;
    else if (state_q == STROBE && done) err_q <= !in_range || (rw_q && bus.reg_size == 3'd0);
  assign bus.rsp_err = err_q;
`endif
endmodule

// File: tb/tb_periph_bus_sequencer.sv
// tb_periph_bus_sequencer: directed and randomized commands checked against a table-based peripheral model.
module tb_periph_bus_sequencer;
  localparam int NP = 8, S = 2, T = 2, H = 1;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic c_valid, c_rw, r_ready;
  logic [6:0] c_periph;
  logic [7:0] c_reg;
  logic [31:0] c_wdata;
  logic [31:0] ptab [NP];
  logic [2:0] stab [NP];
  logic [31:0] p_rdata;
  logic [2:0] p_size;
  periph_bus_sequencer_if #(.NUM_PERIPH(NP)) bus ();
  periph_bus_sequencer #(.NUM_PERIPH(NP), .SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H))
    dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.cmd_valid  = c_valid;
  assign bus.cmd_periph = c_periph;
  assign bus.cmd_reg    = c_reg;
  assign bus.cmd_rw     = c_rw;
  assign bus.cmd_wdata  = c_wdata;
  assign bus.rsp_ready  = r_ready;
  assign bus.bus_rdata  = p_rdata;
  assign bus.reg_size   = p_size;
  // peripherals answer only while selected; otherwise the bus carries junk
  always_comb begin
    p_rdata = 32'hBAD0_BAD0;
    p_size  = 3'd7;
    for (int i = 0; i < NP; i++)
      if (bus.select[i]) begin
        p_rdata = ptab[i] ^ {24'h0, bus.reg_addr};
        p_size  = stab[i];
      end
  end
  typedef struct {
    int wait_c, lat, rise, fall, oe_c, rw0_c, stable_c, multi, rsp_bad;
    logic [NP-1:0] sel_or;
    logic [31:0] data;
    logic [2:0] size;
    logic err, rdy;
  } obs_t;
  function automatic logic [34:0] model(input logic [6:0] p, input logic [7:0] r, input logic rw_);
    if (!rw_ || int'(p) >= NP) return '0;
    return {stab[int'(p)], ptab[int'(p)] ^ {24'h0, r}};
  endfunction
  function automatic logic model_err(input logic [6:0] p, input logic rw_);
    if (int'(p) >= NP) return 1'b1;
    return rw_ && stab[int'(p)] == 3'd0;
  endfunction
  task automatic do_cmd(input logic [6:0] p, input logic [7:0] r, input logic rw_,
                        input logic [31:0] wd, input int dly, output obs_t o);
    int k;
    o.wait_c = 0; o.lat = 0; o.rise = 0; o.fall = 0; o.oe_c = 0; o.rw0_c = 0;
    o.stable_c = 0; o.multi = 0; o.rsp_bad = 0; o.sel_or = '0; o.data = '0;
    o.size = '0; o.err = 1'b0; o.rdy = 1'b0;
    c_valid = 1'b1; c_periph = p; c_reg = r; c_rw = rw_; c_wdata = wd;
    while (!bus.cmd_ready && o.wait_c < 50) begin @(negedge clk); o.wait_c++; end
    @(negedge clk);
    c_valid = 1'b0; c_periph = 7'($urandom); c_reg = 8'($urandom); c_rw = 1'($urandom); c_wdata = $urandom;
    k = 1;
    while (!bus.rsp_valid && k < 40) begin
      if (bus.select != '0 && o.rise == 0) o.rise = k;
      if (bus.select == '0 && o.rise != 0 && o.fall == 0) o.fall = k;
      if ($countones(bus.select) > 1) o.multi++;
      o.sel_or |= bus.select;
      if (bus.bus_wdata_oe) o.oe_c++;
      if (!bus.rw) o.rw0_c++;
      if (bus.reg_addr == r && bus.rw == rw_ && bus.bus_wdata_oe == !rw_ && (rw_ || bus.bus_wdata == wd)) o.stable_c++;
      @(negedge clk); k++;
    end
    o.lat = k;
    o.sel_or |= bus.select;
    if (bus.bus_wdata_oe) o.oe_c++;
    if (!bus.rw) o.rw0_c++;
    o.rdy = bus.cmd_ready;
    o.data = bus.rsp_data;
    o.size = bus.rsp_size;
`ifdef SEQ_INVALID_DETECT_EN
    o.err = bus.rsp_err;
`endif
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.cmd_ready || bus.rsp_data !== o.data || bus.rsp_size !== o.size) o.rsp_bad++;
    end
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
  endtask
  task automatic test_reset;
    #2 rst = 1'b1;
    c_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.select !== '0 || bus.bus_wdata_oe !== 1'b0 || bus.rw !== 1'b1 || bus.reg_addr !== 8'h0 || bus.bus_wdata !== 32'h0)
      begin errors++; $display("FAIL reset_bus sel=%h oe=%b rw=%b addr=%h wd=%h exp 0/0/1/0/0", bus.select, bus.bus_wdata_oe, bus.rw, bus.reg_addr, bus.bus_wdata); end
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0 || bus.rsp_size !== 3'h0 || bus.cmd_ready !== 1'b0)
      begin errors++; $display("FAIL reset_rsp valid=%b data=%h size=%h ready=%b exp 0/0/0/0", bus.rsp_valid, bus.rsp_data, bus.rsp_size, bus.cmd_ready); end
    c_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.cmd_ready); end
  endtask
  task automatic test_write;
    obs_t o;
    do_cmd(7'd3, 8'h10, 1'b0, 32'hDEADBEEF, 0, o);
    checks++; if (o.rise != S + 1 || o.fall != S + T + 1) begin errors++; $display("FAIL write_sel_timing rise=%0d fall=%0d exp %0d %0d", o.rise, o.fall, S + 1, S + T + 1); end
    checks++; if (o.sel_or !== NP'(1) << 3 || o.multi != 0) begin errors++; $display("FAIL write_sel got %b multi=%0d exp %b", o.sel_or, o.multi, NP'(1) << 3); end
    checks++; if (o.stable_c != S + T + H || o.oe_c != S + T + H || o.rw0_c != S + T + H) begin errors++; $display("FAIL write_bus stable=%0d oe=%0d rw0=%0d exp %0d", o.stable_c, o.oe_c, o.rw0_c, S + T + H); end
    checks++; if (o.lat != S + T + H + 1) begin errors++; $display("FAIL write_lat got %0d exp %0d", o.lat, S + T + H + 1); end
    checks++; if (o.data !== 32'h0 || o.size !== 3'h0) begin errors++; $display("FAIL write_rsp got %h/%h exp 0/0", o.data, o.size); end
  endtask
  task automatic test_read;
    obs_t o;
    ptab[5] = 32'h12345678 ^ 32'h02;
    stab[5] = 3'd4;
    do_cmd(7'd5, 8'h02, 1'b1, $urandom, 0, o);
    checks++; if (o.data !== 32'h12345678 || o.size !== 3'd4) begin errors++; $display("FAIL read_rsp got %h/%h exp 12345678/4", o.data, o.size); end
    checks++; if (o.oe_c != 0 || o.rw0_c != 0) begin errors++; $display("FAIL read_oe oe=%0d rw0=%0d exp 0 0", o.oe_c, o.rw0_c); end
    checks++; if (o.sel_or !== NP'(1) << 5 || o.rise != S + 1 || o.fall != S + T + 1) begin errors++; $display("FAIL read_sel got %b rise=%0d fall=%0d", o.sel_or, o.rise, o.fall); end
    checks++; if (o.lat != S + T + H + 1) begin errors++; $display("FAIL read_lat got %0d exp %0d", o.lat, S + T + H + 1); end
  endtask
  task automatic test_back_to_back;
    obs_t o1, o2;
    logic [34:0] e;
    do_cmd(7'd1, 8'h33, 1'b1, 32'h0, 10, o1);
    e = model(7'd1, 8'h33, 1'b1);
    checks++; if (o1.rsp_bad != 0 || o1.rdy !== 1'b0) begin errors++; $display("FAIL stall_stable bad=%0d ready=%b exp 0 0", o1.rsp_bad, o1.rdy); end
    checks++; if ({o1.size, o1.data} !== e) begin errors++; $display("FAIL stall_rsp got %h exp %h", {o1.size, o1.data}, e); end
    do_cmd(7'd2, 8'h44, 1'b0, 32'hCAFEF00D, 0, o2);
    checks++; if (o2.wait_c != 0) begin errors++; $display("FAIL b2b_accept wait=%0d exp 0", o2.wait_c); end
    checks++; if (o2.lat != S + T + H + 1 || o2.stable_c != S + T + H) begin errors++; $display("FAIL b2b_timing lat=%0d stable=%0d", o2.lat, o2.stable_c); end
  endtask
  task automatic test_reset_strobe;
    int bad;
    c_valid = 1'b1; c_periph = 7'd4; c_reg = 8'h5A; c_rw = 1'b0; c_wdata = 32'h0BADF00D;
    @(negedge clk);
    c_valid = 1'b0;
    repeat (S) @(negedge clk);
    checks++; if (bus.select !== NP'(1) << 4) begin errors++; $display("FAIL rst_pre_sel got %b exp %b", bus.select, NP'(1) << 4); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.select !== '0 || bus.bus_wdata_oe !== 1'b0) begin errors++; $display("FAIL rst_async sel=%b oe=%b exp 0 0", bus.select, bus.bus_wdata_oe); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b1 || bus.rw !== 1'b1) begin errors++; $display("FAIL rst_idle ready=%b rw=%b exp 1 1", bus.cmd_ready, bus.rw); end
    bad = 0;
    repeat (10) begin @(negedge clk); if (bus.rsp_valid !== 1'b0 || bus.select !== '0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_no_rsp got %0d bad cycles exp 0", bad); end
  endtask
  task automatic test_out_of_range;
    obs_t o;
    do_cmd(7'd9, 8'h21, 1'b1, 32'h0, 0, o);
    checks++; if (o.sel_or !== '0 || o.rise != 0) begin errors++; $display("FAIL oor_sel got %b exp 0", o.sel_or); end
    checks++; if (o.lat != S + T + H + 1 || o.data !== 32'h0 || o.size !== 3'h0) begin errors++; $display("FAIL oor_rsp lat=%0d got %h/%h exp %0d 0/0", o.lat, o.data, o.size, S + T + H + 1); end
`ifdef SEQ_INVALID_DETECT_EN
    checks++; if (o.err !== 1'b1) begin errors++; $display("FAIL oor_err got %b exp 1", o.err); end
`endif
  endtask
`ifdef SEQ_INVALID_DETECT_EN
  task automatic test_err;
    obs_t o;
    stab[2] = 3'd0;
    do_cmd(7'd2, 8'h08, 1'b1, 32'h0, 0, o);
    checks++; if (o.err !== 1'b1 || o.size !== 3'd0) begin errors++; $display("FAIL err_size0 err=%b size=%h exp 1 0", o.err, o.size); end
    stab[2] = 3'd2;
    do_cmd(7'd2, 8'h08, 1'b1, 32'h0, 0, o);
    checks++; if (o.err !== 1'b0 || o.size !== 3'd2) begin errors++; $display("FAIL err_size2 err=%b size=%h exp 0 2", o.err, o.size); end
  endtask
`endif
  task automatic test_random;
    obs_t o;
    logic [6:0] p;
    logic [7:0] r;
    logic rw_, inr;
    logic [34:0] e;
    for (int n = 0; n < 40; n++) begin
      p = 7'($urandom_range(0, 15));
      r = 8'($urandom);
      rw_ = 1'($urandom);
      inr = int'(p) < NP;
      if (inr) stab[int'(p)] = 3'($urandom);
      do_cmd(p, r, rw_, $urandom, $urandom_range(0, 3), o);
      e = model(p, r, rw_);
      checks++; if ({o.size, o.data} !== e) begin errors++; $display("FAIL rnd%0d_rsp p=%0d rw=%b got %h exp %h", n, p, rw_, {o.size, o.data}, e); end
      checks++; if (o.sel_or !== (inr ? NP'(1) << p : NP'(0)) || o.multi != 0) begin errors++; $display("FAIL rnd%0d_sel p=%0d got %b multi=%0d", n, p, o.sel_or, o.multi); end
      checks++; if (o.rise != (inr ? S + 1 : 0) || o.fall != (inr ? S + T + 1 : 0)) begin errors++; $display("FAIL rnd%0d_edges rise=%0d fall=%0d inr=%b", n, o.rise, o.fall, inr); end
      checks++; if (o.lat != S + T + H + 1 || o.wait_c != 0 || o.stable_c != S + T + H) begin errors++; $display("FAIL rnd%0d_timing lat=%0d wait=%0d stable=%0d", n, o.lat, o.wait_c, o.stable_c); end
      checks++; if (o.oe_c != (rw_ ? 0 : S + T + H) || o.rsp_bad != 0) begin errors++; $display("FAIL rnd%0d_oe oe=%0d bad=%0d rw=%b", n, o.oe_c, o.rsp_bad, rw_); end
`ifdef SEQ_INVALID_DETECT_EN
      checks++; if (o.err !== model_err(p, rw_)) begin errors++; $display("FAIL rnd%0d_err got %b exp %b", n, o.err, model_err(p, rw_)); end
`endif
    end
  endtask
  initial begin
    c_valid = 1'b0; c_periph = '0; c_reg = '0; c_rw = 1'b0; c_wdata = '0; r_ready = 1'b0;
    for (int i = 0; i < NP; i++) begin ptab[i] = $urandom; stab[i] = 3'($urandom_range(1, 7)); end
    test_reset;
    test_write;
    test_read;
    test_back_to_back;
    test_reset_strobe;
    test_out_of_range;
`ifdef SEQ_INVALID_DETECT_EN
    test_err;
`endif
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
